fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO, the successor to the fixed 8x8 memory buffer in the SPI data path. Data width and depth are configurable, with selectable standard or first-word-fall-through (FWFT) read mode. It adds full/empty flags, programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. It buffers bytes between the SPI shift logic and the host-side interface.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  global enable; when 0, no push, pop or error update occurs
write  input  1  push request, sampled at rising clk
read  input  1  pop request, sampled at rising clk
data_in  input  DATA_W  write data
data_out  output  DATA_W  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
clr_err  input  1  synchronous clear of overflow/underflow, independent of enable

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0 (or 1 if AF_LEVEL==0, which is disallowed), overflow=0, underflow=0. Memory array is not reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count is a separate up/down counter. All flags are decoded from registered count, so they are valid in the same cycle as count.
- rd_ok = enable & read & !empty.
- wr_ok = enable & write & (!full | rd_ok). A push is allowed on a full FIFO only when a pop occurs in the same cycle.
- Push: mem[wr_ptr] <= data_in; wr_ptr++.
- Pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous read and write when empty: the write is accepted, the read is rejected (underflow=1), and count becomes 1. There is no pass-through of write data to the read side.
- Standard mode (FWFT=0):
  - On rd_ok, data_out <= mem[rd_ptr] at the same edge, so data is visible 1 cycle after the read is sampled.
  - data_out holds its value when there is no pop, including while empty.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally while !empty; a pop advances to the next word.
  - data_out = 0 when empty.
  - The first written word appears on data_out 1 cycle after its write edge.
- Error flags:
  - overflow <= 1 when enable & write & !wr_ok.
  - underflow <= 1 when enable & read & !rd_ok.
  - Both flags stay set until clr_err=1 at a rising edge or reset.
  - If clr_err and a new error occur in the same cycle, the error wins and the flag stays 1.
  - A rejected access never changes pointers, count or memory contents.
- enable=0: all state holds, including data_out; clr_err still acts.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). Memory contents are undefined thereafter and must not be relied upon.
- Implementation is single clock, with no combinational path from read/write to full/empty/count.

Test Plan:
1. Reset, then push 02,04,08,16,32,64,6f,ff on consecutive cycles (FWFT=0, DEPTH=8) -> count steps 1..8; almost_full rises at count=6; full=1 after the 8th edge; empty=0; overflow=0.
2. From full, push 0xAA -> overflow=1, count stays 8. Then pop 8 times -> data_out is 02,04,08,16,32,64,6f,ff, each 1 cycle after its read; empty=1 and almost_empty=1 at the end; no 0xAA is ever read.
3. Read while empty -> underflow=1, data_out holds ff, count=0. Pulse clr_err -> underflow=0 and overflow=0. With clr_err high and a simultaneous empty read -> underflow remains 1.
4. Fill to full, then assert read and write together with data 0x55 for 3 cycles -> count stays 8; outputs are 02,04,08; no overflow; subsequent drain ends with 55,55,55.
5. Push 4 words, assert rst_n=0 between clock edges -> count=0, empty=1, data_out=0 immediately without waiting for clk. Release reset, push 0x11 -> count=1.
6. FWFT=1 build: push 0x21, 0x42 -> data_out=0x21 one cycle after the first write with no read; one pop -> data_out=0x42; second pop -> empty=1, data_out=0. Repeat any pop with enable=0 -> no change in state.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// ---------------
// Parametrised single-clock FIFO that sits between the SPI shift logic and
// the host-side interface. It has two read modes:
//   - standard: data_out is registered and updates on a pop.
//   - first-word-fall-through: data_out shows the head word combinationally.
// All status flags are decoded from the registered occupancy counter, so
// read/write never reach full/empty/count through combinational logic.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   enable       global enable; gates push, pop and error-flag setting
//   write        push request
//   read         pop request
//   data_in      write data (DATA_W bits)
//   data_out     read data (DATA_W bits)
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy, 0..DEPTH
//   overflow     sticky, set when a write is rejected
//   underflow    sticky, set when a read is rejected
//   clr_err      synchronous clear of overflow/underflow, ignores enable

module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      write,
    input  logic                      read,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_ok;
    logic              wr_ok;

    // Flags come straight from the registered count.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A pop needs data present; a push into a full FIFO is only allowed when
    // a pop frees a slot in the same cycle. A write into an empty FIFO never
    // satisfies a same-cycle read (no bypass path).
    assign rd_ok = enable & read & ~empty;
    assign wr_ok = enable & write & (~full | rd_ok);

    // Storage array; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally; count moves only when exactly one side acts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (enable & write & ~wr_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (enable & read & ~rd_ok) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Read-data path depends on the selected mode.
    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;

            // Registered output: only a successful pop loads a new word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: a standard-mode instance driven
// from a table of hand-computed vectors, plus hand-written sequences for
// asynchronous reset and a first-word-fall-through instance.

module tb_fifo_sync_param;

    logic       clk;
    logic       rst_n;

    // Standard-mode instance signals
    logic       enable, write, read, clr_err;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    // FWFT instance signals
    logic       f_enable, f_write, f_read, f_clr_err;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int num_compared;
    int num_mismatched;

    typedef struct {
        logic       en;
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        logic [3:0] cnt;
        logic [7:0] dout;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_std (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .write        (write),
        .read         (read),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (f_enable),
        .write        (f_write),
        .read         (f_read),
        .data_in      (f_data_in),
        .data_out     (f_data_out),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow),
        .clr_err      (f_clr_err)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check in the bench goes through here
    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        num_compared++;
        if (act !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic addv(input logic en, input logic wr, input logic rd, input logic clr,
                        input logic [7:0] din, input logic [3:0] cnt, input logic [7:0] dout,
                        input logic ovf, input logic udf);
        vec_t v;
        v.en = en; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    // Drive the standard instance at the falling edge, let one rising edge pass
    task automatic stepStd(input logic en, input logic wr, input logic rd,
                           input logic clr, input logic [7:0] din);
        @(negedge clk);
        enable = en; write = wr; read = rd; clr_err = clr; data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic stepFwft(input logic en, input logic wr, input logic rd, input logic [7:0] din);
        @(negedge clk);
        f_enable = en; f_write = wr; f_read = rd; f_data_in = din;
        @(posedge clk);
        #1;
    endtask

    // Apply one table vector and compare every output; the status flags are
    // derived from the expected count using the DEPTH=8, AF=6, AE=1 thresholds.
    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        stepStd(v.en, v.wr, v.rd, v.clr, v.din);
        checkOutput("count",        idx, 32'(count),        32'(v.cnt));
        checkOutput("data_out",     idx, 32'(data_out),     32'(v.dout));
        checkOutput("full",         idx, 32'(full),         32'(v.cnt == 4'd8));
        checkOutput("empty",        idx, 32'(empty),        32'(v.cnt == 4'd0));
        checkOutput("almost_full",  idx, 32'(almost_full),  32'(v.cnt >= 4'd6));
        checkOutput("almost_empty", idx, 32'(almost_empty), 32'(v.cnt <= 4'd1));
        checkOutput("overflow",     idx, 32'(overflow),     32'(v.ovf));
        checkOutput("underflow",    idx, 32'(underflow),    32'(v.udf));
    endtask

    initial begin
        logic [7:0] pattern [8];
        num_compared   = 0;
        num_mismatched = 0;
        pattern = '{8'h02, 8'h04, 8'h08, 8'h16, 8'h32, 8'h64, 8'h6f, 8'hff};

        rst_n = 1'b0;
        enable = 0; write = 0; read = 0; clr_err = 0; data_in = 8'h00;
        f_enable = 0; f_write = 0; f_read = 0; f_clr_err = 0; f_data_in = 8'h00;

        // Fill phase: counts 1..8, data_out stays at its reset value
        for (int i = 0; i < 8; i++)
            addv(1, 1, 0, 0, pattern[i], 4'(i + 1), 8'h00, 0, 0);
        // Push into full FIFO is rejected
        addv(1, 1, 0, 0, 8'hAA, 4'd8, 8'h00, 1, 0);
        // Drain: each word appears one cycle after its read is sampled
        for (int i = 0; i < 8; i++)
            addv(1, 0, 1, 0, 8'h00, 4'(7 - i), pattern[i], 1, 0);
        // Empty read: underflow, data_out holds last word
        addv(1, 0, 1, 0, 8'h00, 4'd0, 8'hff, 1, 1);
        // Clear both errors
        addv(1, 0, 0, 1, 8'h00, 4'd0, 8'hff, 0, 0);
        // Clear and new empty read together: error wins
        addv(1, 0, 1, 1, 8'h00, 4'd0, 8'hff, 0, 1);
        addv(1, 0, 0, 1, 8'h00, 4'd0, 8'hff, 0, 0);
        // Refill
        for (int i = 0; i < 8; i++)
            addv(1, 1, 0, 0, pattern[i], 4'(i + 1), 8'hff, 0, 0);
        // Simultaneous read/write on full: count stays 8, no overflow
        for (int i = 0; i < 3; i++)
            addv(1, 1, 1, 0, 8'h55, 4'd8, pattern[i], 0, 0);
        // Drain the rest
        for (int i = 0; i < 5; i++)
            addv(1, 0, 1, 0, 8'h00, 4'(7 - i), pattern[i + 3], 0, 0);
        for (int i = 0; i < 3; i++)
            addv(1, 0, 1, 0, 8'h00, 4'(2 - i), 8'h55, 0, 0);
        // Disabled read of empty FIFO: nothing changes, no underflow
        addv(0, 0, 1, 0, 8'h00, 4'd0, 8'h55, 0, 0);
        // Enabled empty read sets underflow; disabled clr_err still clears it
        addv(1, 0, 1, 0, 8'h00, 4'd0, 8'h55, 0, 1);
        addv(0, 0, 0, 1, 8'h00, 4'd0, 8'h55, 0, 0);
        // Disabled write into empty FIFO is ignored
        addv(0, 1, 0, 0, 8'h99, 4'd0, 8'h55, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count",     0, 32'(count),        32'd0);
        checkOutput("rst_data_out",  0, 32'(data_out),     32'h00);
        checkOutput("rst_empty",     0, 32'(empty),        32'd1);
        checkOutput("rst_full",      0, 32'(full),         32'd0);
        checkOutput("rst_ae",        0, 32'(almost_empty), 32'd1);
        checkOutput("rst_af",        0, 32'(almost_full),  32'd0);
        checkOutput("rst_ovf",       0, 32'(overflow),     32'd0);
        checkOutput("rst_udf",       0, 32'(underflow),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(i);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++)
            stepStd(1, 1, 0, 0, 8'hA1 + 8'(i));
        checkOutput("pre_rst_count", 0, 32'(count),    32'd4);
        checkOutput("pre_rst_dout",  0, 32'(data_out), 32'h55);
        @(negedge clk);
        enable = 0; write = 0; read = 0; clr_err = 0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_count", 0, 32'(count),    32'd0);
        checkOutput("async_empty", 0, 32'(empty),    32'd1);
        checkOutput("async_dout",  0, 32'(data_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        stepStd(1, 1, 0, 0, 8'h11);
        checkOutput("post_rst_count", 0, 32'(count),    32'd1);
        checkOutput("post_rst_empty", 0, 32'(empty),    32'd0);
        checkOutput("post_rst_dout",  0, 32'(data_out), 32'h00);
        stepStd(1, 0, 1, 0, 8'h00);
        checkOutput("post_rst_pop", 0, 32'(data_out), 32'h11);
        checkOutput("post_rst_cnt", 0, 32'(count),    32'd0);
        stepStd(0, 0, 0, 0, 8'h00);

        // First-word-fall-through instance
        checkOutput("fwft_rst_dout", 0, 32'(f_data_out), 32'h00);
        stepFwft(1, 1, 0, 8'h21);
        checkOutput("fwft_first_dout", 0, 32'(f_data_out), 32'h21);
        checkOutput("fwft_first_cnt",  0, 32'(f_count),    32'd1);
        stepFwft(1, 1, 0, 8'h42);
        checkOutput("fwft_second_dout", 0, 32'(f_data_out), 32'h21);
        checkOutput("fwft_second_cnt",  0, 32'(f_count),    32'd2);
        stepFwft(0, 0, 1, 8'h00);
        checkOutput("fwft_dis_dout", 0, 32'(f_data_out), 32'h21);
        checkOutput("fwft_dis_cnt",  0, 32'(f_count),    32'd2);
        stepFwft(1, 0, 1, 8'h00);
        checkOutput("fwft_pop1_dout", 0, 32'(f_data_out), 32'h42);
        checkOutput("fwft_pop1_cnt",  0, 32'(f_count),    32'd1);
        stepFwft(1, 0, 1, 8'h00);
        checkOutput("fwft_pop2_dout",  0, 32'(f_data_out), 32'h00);
        checkOutput("fwft_pop2_empty", 0, 32'(f_empty),    32'd1);
        checkOutput("fwft_pop2_udf",   0, 32'(f_underflow), 32'd0);
        stepFwft(0, 0, 1, 8'h00);
        checkOutput("fwft_dis2_cnt",  0, 32'(f_count),     32'd0);
        checkOutput("fwft_dis2_udf",  0, 32'(f_underflow), 32'd0);
        stepFwft(0, 0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
